// File: rtl/asm_encoder_pkg.sv
// Shared types and constants for the ASCII-to-MIPS line encoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package asm_encoder_pkg;

  localparam logic [2:0] MAX_MNEM   = 3'd6;
  localparam logic [3:0] MAX_DIGITS = 4'd8;
  localparam logic [47:0] BLANK     = {6{8'h20}};

  typedef enum logic [2:0] {S_IDLE, S_MNEM, S_GAP, S_OPND, S_SKIP, S_EMIT} state_t;

  typedef enum logic [3:0] {
    CLS_RRR, CLS_RRS, CLS_RR, CLS_RD, CLS_RS, CLS_JALR, CLS_NONE, CLS_IMM,
    CLS_LUI, CLS_MEM, CLS_BR2, CLS_BR1, CLS_REGIMM, CLS_JMP, CLS_COP0
  } cls_t;

  typedef struct packed {
    logic       known;
    cls_t       cls;
    logic [5:0] opc;
    logic [5:0] fcode;  // funct, REGIMM rt code or COP0 rs code
    logic [1:0] nops;
  } lut_t;

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J     = 6'h02, OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04, OP_BNE    = 6'h05, OP_BLEZ  = 6'h06, OP_BGTZ = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08, OP_ADDIU  = 6'h09, OP_SLTI  = 6'h0A, OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C, OP_ORI    = 6'h0D, OP_XORI  = 6'h0E, OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_COP0    = 6'h10;
  localparam logic [5:0] OP_LB      = 6'h20, OP_LH     = 6'h21, OP_LW    = 6'h23, OP_LBU  = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25, OP_SB     = 6'h28, OP_SH    = 6'h29, OP_SW   = 6'h2B;

  // SPECIAL funct codes
  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA   = 6'h03, FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06, FN_SRAV = 6'h07, FN_JR    = 6'h08, FN_JALR  = 6'h09;
  localparam logic [5:0] FN_SYSC = 6'h0C, FN_BRE  = 6'h0D, FN_MFHI  = 6'h10, FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO = 6'h12, FN_MTLO = 6'h13, FN_MULT  = 6'h18, FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV  = 6'h1A, FN_DIVU = 6'h1B, FN_ADD   = 6'h20, FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22, FN_SUBU = 6'h23, FN_AND   = 6'h24, FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26, FN_NOR  = 6'h27, FN_SLT   = 6'h2A, FN_SLTU  = 6'h2B;
  localparam logic [5:0] FN_ERET = 6'h18, FN_NOP  = 6'h00;

  // REGIMM rt codes and COP0 rs codes
  localparam logic [5:0] RT_BLTZ = 6'h00, RT_BGEZ = 6'h01, RT_BLTZAL = 6'h10, RT_BGEZAL = 6'h11;
  localparam logic [5:0] CO_MF   = 6'h00, CO_MT   = 6'h04;

  function automatic logic [1:0] cls_nops(cls_t c);
    case (c)
      CLS_RRR, CLS_RRS, CLS_IMM, CLS_MEM, CLS_BR2:             return 2'd3;
      CLS_RR, CLS_JALR, CLS_LUI, CLS_BR1, CLS_REGIMM, CLS_COP0: return 2'd2;
      CLS_RD, CLS_RS, CLS_JMP:                                 return 2'd1;
      default:                                                 return 2'd0;
    endcase
  endfunction

  function automatic lut_t mk(cls_t c, logic [5:0] opc, logic [5:0] fc);
    lut_t e;
    e.known = 1'b1;
    e.cls   = c;
    e.opc   = opc;
    e.fcode = fc;
    e.nops  = cls_nops(c);
    return e;
  endfunction

endpackage

// File: rtl/asm_lut.sv
// Mnemonic lookup: packed 6-char mnemonic -> {known, class, opcode, funct/code, operand count}.
// Latency: combinational.
// Backpressure: none.
module asm_lut
  import asm_encoder_pkg::*;
(
  input  logic [47:0] mnem,
  output lut_t        ent
);

  // Table lookup; unknown spellings return known=0
  always_comb begin
    ent = '0;
    case (mnem)
      "AND   ": ent = mk(CLS_RRR, OP_SPECIAL, FN_AND);
      "OR    ": ent = mk(CLS_RRR, OP_SPECIAL, FN_OR);
      "XOR   ": ent = mk(CLS_RRR, OP_SPECIAL, FN_XOR);
      "NOR   ": ent = mk(CLS_RRR, OP_SPECIAL, FN_NOR);
      "ADD   ": ent = mk(CLS_RRR, OP_SPECIAL, FN_ADD);
      "ADDU  ": ent = mk(CLS_RRR, OP_SPECIAL, FN_ADDU);
      "SUB   ": ent = mk(CLS_RRR, OP_SPECIAL, FN_SUB);
      "SUBU  ": ent = mk(CLS_RRR, OP_SPECIAL, FN_SUBU);
      "SLT   ": ent = mk(CLS_RRR, OP_SPECIAL, FN_SLT);
      "SLTU  ": ent = mk(CLS_RRR, OP_SPECIAL, FN_SLTU);
      "SLLV  ": ent = mk(CLS_RRR, OP_SPECIAL, FN_SLLV);
      "SRLV  ": ent = mk(CLS_RRR, OP_SPECIAL, FN_SRLV);
      "SRAV  ": ent = mk(CLS_RRR, OP_SPECIAL, FN_SRAV);
      "SLL   ": ent = mk(CLS_RRS, OP_SPECIAL, FN_SLL);
      "SRL   ": ent = mk(CLS_RRS, OP_SPECIAL, FN_SRL);
      "SRA   ": ent = mk(CLS_RRS, OP_SPECIAL, FN_SRA);
      "MULT  ": ent = mk(CLS_RR, OP_SPECIAL, FN_MULT);
      "MULTU ": ent = mk(CLS_RR, OP_SPECIAL, FN_MULTU);
      "DIV   ": ent = mk(CLS_RR, OP_SPECIAL, FN_DIV);
      "DIVU  ": ent = mk(CLS_RR, OP_SPECIAL, FN_DIVU);
      "MFHI  ": ent = mk(CLS_RD, OP_SPECIAL, FN_MFHI);
      "MFLO  ": ent = mk(CLS_RD, OP_SPECIAL, FN_MFLO);
      "MTHI  ": ent = mk(CLS_RS, OP_SPECIAL, FN_MTHI);
      "MTLO  ": ent = mk(CLS_RS, OP_SPECIAL, FN_MTLO);
      "JR    ": ent = mk(CLS_RS, OP_SPECIAL, FN_JR);
      "JALR  ": ent = mk(CLS_JALR, OP_SPECIAL, FN_JALR);
      "SYSC  ": ent = mk(CLS_NONE, OP_SPECIAL, FN_SYSC);
      "BRE   ": ent = mk(CLS_NONE, OP_SPECIAL, FN_BRE);
      "ERET  ": ent = mk(CLS_NONE, OP_COP0, FN_ERET);
      "NOP   ": ent = mk(CLS_NONE, OP_SPECIAL, FN_NOP);
      "ANDI  ": ent = mk(CLS_IMM, OP_ANDI, 6'h00);
      "ORI   ": ent = mk(CLS_IMM, OP_ORI, 6'h00);
      "XORI  ": ent = mk(CLS_IMM, OP_XORI, 6'h00);
      "ADDI  ": ent = mk(CLS_IMM, OP_ADDI, 6'h00);
      "ADDIU ": ent = mk(CLS_IMM, OP_ADDIU, 6'h00);
      "SLTI  ": ent = mk(CLS_IMM, OP_SLTI, 6'h00);
      "SLTIU ": ent = mk(CLS_IMM, OP_SLTIU, 6'h00);
      "LUI   ": ent = mk(CLS_LUI, OP_LUI, 6'h00);
      "LB    ": ent = mk(CLS_MEM, OP_LB, 6'h00);
      "LBU   ": ent = mk(CLS_MEM, OP_LBU, 6'h00);
      "LH    ": ent = mk(CLS_MEM, OP_LH, 6'h00);
      "LHU   ": ent = mk(CLS_MEM, OP_LHU, 6'h00);
      "LW    ": ent = mk(CLS_MEM, OP_LW, 6'h00);
      "SB    ": ent = mk(CLS_MEM, OP_SB, 6'h00);
      "SH    ": ent = mk(CLS_MEM, OP_SH, 6'h00);
      "SW    ": ent = mk(CLS_MEM, OP_SW, 6'h00);
      "BEQ   ": ent = mk(CLS_BR2, OP_BEQ, 6'h00);
      "BNE   ": ent = mk(CLS_BR2, OP_BNE, 6'h00);
      "BGTZ  ": ent = mk(CLS_BR1, OP_BGTZ, 6'h00);
      "BLEZ  ": ent = mk(CLS_BR1, OP_BLEZ, 6'h00);
      "BGEZ  ": ent = mk(CLS_REGIMM, OP_REGIMM, RT_BGEZ);
      "BGEZAL": ent = mk(CLS_REGIMM, OP_REGIMM, RT_BGEZAL);
      "BLTZ  ": ent = mk(CLS_REGIMM, OP_REGIMM, RT_BLTZ);
      "BLTZAL": ent = mk(CLS_REGIMM, OP_REGIMM, RT_BLTZAL);
      "J     ": ent = mk(CLS_JMP, OP_J, 6'h00);
      "JAL   ": ent = mk(CLS_JMP, OP_JAL, 6'h00);
      "MFC0  ": ent = mk(CLS_COP0, OP_COP0, CO_MF);
      "MTOC0 ": ent = mk(CLS_COP0, OP_COP0, CO_MT);
      default:  ent = '0;
    endcase
  end

endmodule

// File: rtl/asm_encoder.sv
// Serial ASCII line -> 32-bit MIPS word encoder (one instruction per LF-terminated line).
// Latency: out_valid rises the cycle after the terminating LF is accepted.
// Backpressure: result held in EMIT until out_ready; in_ready is low for the whole EMIT state.
module asm_encoder
  import asm_encoder_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_byte,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err
);

  state_t      state;
  logic [47:0] mnem;
  logic [2:0]  mlen;
  logic [25:0] op0;     // wide enough for a jump target
  logic [15:0] op1, op2;
  logic [1:0]  opcnt;
  logic [25:0] acc;     // operand being shifted in, already truncated to 26 bits
  logic [3:0]  dcnt;
  logic        err;
  lut_t        ent;

  logic        take, is_upper, is_digit, is_hex, is_sp, is_lf, is_cr, line_end, line_err;
  logic [3:0]  hexv;
  logic [25:0] f0;
  logic [15:0] f1, f2;
  logic [1:0]  fcnt;
  logic [31:0] enc;

  asm_lut u_lut (.mnem(mnem), .ent(ent));

  // Character classification of the incoming byte
  always_comb begin
    take     = in_valid && in_ready;
    is_upper = (in_byte >= 8'h41) && (in_byte <= 8'h5A);
    is_digit = (in_byte >= 8'h30) && (in_byte <= 8'h39);
    is_hex   = is_digit || ((in_byte >= 8'h41) && (in_byte <= 8'h46));
    is_sp    = (in_byte == 8'h20);
    is_lf    = (in_byte == 8'h0A);
    is_cr    = (in_byte == 8'h0D);
    hexv     = in_byte[3:0] + (in_byte[6] ? 4'd9 : 4'd0);
    line_end = take && is_lf && (state inside {S_MNEM, S_GAP, S_OPND, S_SKIP});
  end

  // Operand set as it stands once the LF lands (an operand still in OPND is included)
  always_comb begin
    f0   = op0;
    f1   = op1;
    f2   = op2;
    fcnt = opcnt;
    if (state == S_OPND) begin
      fcnt = opcnt + 2'd1;
      case (opcnt)
        2'd0:    f0 = acc;
        2'd1:    f1 = acc[15:0];
        default: f2 = acc[15:0];
      endcase
    end
    line_err = err || !ent.known || (fcnt != ent.nops);
  end

  // Field assembly per operand class
  always_comb begin
    enc = '0;
    case (ent.cls)
      CLS_RRR:    enc = {ent.opc, f1[4:0], f2[4:0], f0[4:0], 5'd0, ent.fcode};
      CLS_RRS:    enc = {ent.opc, 5'd0, f1[4:0], f0[4:0], f2[4:0], ent.fcode};
      CLS_RR:     enc = {ent.opc, f0[4:0], f1[4:0], 10'd0, ent.fcode};
      CLS_RD:     enc = {ent.opc, 10'd0, f0[4:0], 5'd0, ent.fcode};
      CLS_RS:     enc = {ent.opc, f0[4:0], 15'd0, ent.fcode};
      CLS_JALR:   enc = {ent.opc, f1[4:0], 5'd0, f0[4:0], 5'd0, ent.fcode};
      CLS_NONE:   enc = {ent.opc, (ent.opc == OP_COP0), 19'd0, ent.fcode};  // ERET sets CO
      CLS_IMM:    enc = {ent.opc, f1[4:0], f0[4:0], f2};
      CLS_LUI:    enc = {ent.opc, 5'd0, f0[4:0], f1};
      CLS_MEM:    enc = {ent.opc, f1[4:0], f0[4:0], f2};
      CLS_BR2:    enc = {ent.opc, f0[4:0], f1[4:0], f2};
      CLS_BR1:    enc = {ent.opc, f0[4:0], 5'd0, f1};
      CLS_REGIMM: enc = {ent.opc, f0[4:0], ent.fcode[4:0], f1};
      CLS_JMP:    enc = {ent.opc, f0};
      CLS_COP0:   enc = {ent.opc, ent.fcode[4:0], f0[4:0], f1[4:0], 11'd0};
      default:    enc = '0;
    endcase
  end

  // Line parser FSM with registered handshake outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      mnem      <= BLANK;
      mlen      <= '0;
      op0       <= '0;
      op1       <= '0;
      op2       <= '0;
      opcnt     <= '0;
      acc       <= '0;
      dcnt      <= '0;
      err       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (take) begin
          if (is_upper) begin
            mnem  <= {in_byte, BLANK[39:0]};
            mlen  <= 3'd1;
            state <= S_MNEM;
          end else if (!(is_sp || is_lf || is_cr)) begin
            err   <= 1'b1;
            state <= S_SKIP;
          end
        end
        S_MNEM: if (take) begin
          if (is_upper || is_digit) begin
            if (mlen == MAX_MNEM) begin
              err   <= 1'b1;
              state <= S_SKIP;
            end else begin
              for (int i = 0; i < 6; i++)
                if (mlen == i[2:0]) mnem[47-8*i -: 8] <= in_byte;
              mlen <= mlen + 3'd1;
            end
          end else if (is_sp) begin
            state <= S_GAP;
          end else if (!is_lf && !is_cr) begin
            err   <= 1'b1;
            state <= S_SKIP;
          end
        end
        S_GAP: if (take) begin
          if (is_hex) begin
            if (opcnt == 2'd3) begin
              err   <= 1'b1;
              state <= S_SKIP;
            end else begin
              acc   <= {22'd0, hexv};
              dcnt  <= 4'd1;
              state <= S_OPND;
            end
          end else if (!is_sp && !is_lf && !is_cr) begin
            err   <= 1'b1;
            state <= S_SKIP;
          end
        end
        S_OPND: if (take) begin
          if (is_hex) begin
            if (dcnt == MAX_DIGITS) begin
              err   <= 1'b1;
              state <= S_SKIP;
            end else begin
              acc  <= {acc[21:0], hexv};
              dcnt <= dcnt + 4'd1;
            end
          end else if (is_sp) begin
            case (opcnt)
              2'd0:    op0 <= acc;
              2'd1:    op1 <= acc[15:0];
              default: op2 <= acc[15:0];
            endcase
            opcnt <= opcnt + 2'd1;
            state <= S_GAP;
          end else if (!is_lf && !is_cr) begin
            err   <= 1'b1;
            state <= S_SKIP;
          end
        end
        S_EMIT: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          mnem      <= BLANK;
          mlen      <= '0;
          opcnt     <= '0;
          err       <= 1'b0;
          state     <= S_IDLE;
        end
        default: ;  // S_SKIP: discard until LF, handled below
      endcase

      if (line_end) begin
        state     <= S_EMIT;
        in_ready  <= 1'b0;
        out_valid <= 1'b1;
        out_err   <= line_err;
        out_instr <= line_err ? 32'd0 : enc;
      end
    end
  end

endmodule

// File: tb/tb_asm_encoder.sv
// Bench for asm_encoder: drives text lines, scoreboards expected {err, instr} results.
// Latency: n/a.
// Backpressure: exercises out_ready stalls and in_ready gating.
module tb_asm_encoder;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_byte = 8'h00;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic        out_err;

  int checks = 0;
  int failures = 0;
  logic [32:0] exp_q[$];

  always #5 clk = ~clk;

  asm_encoder dut (
    .clk(clk), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err)
  );

  task automatic push_exp(input logic err, input logic [31:0] instr);
    exp_q.push_back({err, instr});
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) begin
      int guard;
      guard = 0;
      in_valid = 1'b1;
      in_byte  = s[i];
      @(negedge clk);
      while (!in_ready && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (!in_ready) begin
        checks++;
        failures++;
        $display("FAIL send_str: in_ready stuck at 0 for byte %h", s[i]);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  // Pops expected results in order as the DUT presents them
  task automatic drain(input int n);
    logic [32:0] e;
    for (int k = 0; k < n; k++) begin
      int guard;
      guard = 0;
      @(negedge clk);
      while (!out_valid && guard < 300) begin
        @(negedge clk);
        guard++;
      end
      checks++;
      if (!out_valid) begin
        failures++;
        $display("FAIL drain timeout: out_valid=0 required 1");
        return;
      end
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected result: got err=%0b instr=%h, none required", out_err, out_instr);
      end else begin
        e = exp_q.pop_front();
        if ({out_err, out_instr} !== e)
          begin
            failures++;
            $display("FAIL result: got err=%0b instr=%h required err=%0b instr=%h",
                     out_err, out_instr, e[32], e[31:0]);
          end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset in_ready: got %b required 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset out_valid: got %b required 0", out_valid); end
    checks++; if (out_instr !== 32'h0) begin failures++; $display("FAIL reset out_instr: got %h required 0", out_instr); end
    checks++; if (out_err !== 1'b0) begin failures++; $display("FAIL reset out_err: got %b required 0", out_err); end
    @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  task automatic test_basic();
    push_exp(1'b0, 32'h00221821);
    push_exp(1'b0, 32'h24412345);  // 16-bit immediate truncation
    push_exp(1'b0, 32'h3C015678);  // exactly MAX_DIGITS digits
    push_exp(1'b0, 32'h40811000);  // MTOC0: rs=00100
    fork
      send_str("ADDU 3 1 2\nADDIU 1 2 12345\nLUI 1 12345678\nMTOC0 1 2\n");
      drain(4);
    join
  endtask

  task automatic test_back_to_back();
    push_exp(1'b0, 32'h3528FFFF);
    push_exp(1'b0, 32'hAFBFFFFC);
    fork
      send_str("ORI 8 9 FFFF\nSW 1F 1D FFFC\n");
      drain(2);
    join
  endtask

  task automatic test_empty_line();
    bit seen;
    push_exp(1'b0, 32'h08000100);
    fork
      send_str("\n  J 100\r\n");
      drain(1);
    join
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin failures++; $display("FAIL empty_line: got extra out_valid, required none"); end
  endtask

  task automatic test_errors();
    push_exp(1'b1, 32'h0);  // unknown mnemonic
    push_exp(1'b1, 32'h0);  // wrong operand count
    push_exp(1'b1, 32'h0);  // unknown (ERETX)
    push_exp(1'b0, 32'h42000018);
    push_exp(1'b1, 32'h0);  // mnemonic too long
    push_exp(1'b1, 32'h0);  // too many digits
    push_exp(1'b1, 32'h0);  // fourth operand
    push_exp(1'b1, 32'h0);  // illegal character
    fork
      send_str("XYZ 1\nADDU 1 2\nERETX\nERET\nADDUXYZ 1\nLUI 1 123456789\nSLL 1 2 3 4\nOR 1 2 g\n");
      drain(8);
    join
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    push_exp(1'b0, 32'h04910010);
    push_exp(1'b0, 32'h00000000);
    send_str("BGEZAL 4 10\n");
    in_valid = 1'b1;
    in_byte  = "N";
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL stall out_valid: got %b required 1", out_valid); end
      checks++; if (out_instr !== 32'h04910010) begin failures++; $display("FAIL stall out_instr: got %h required 04910010", out_instr); end
      checks++; if (out_err !== 1'b0) begin failures++; $display("FAIL stall out_err: got %b required 0", out_err); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL stall in_ready: got %b required 0", in_ready); end
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    fork
      send_str("NOP\n");
      drain(2);
    join
  endtask

  task automatic test_reset_midline();
    send_str("LW 2 ");
    @(negedge clk);
    resetn = 1'b0;
    #2;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midreset in_ready: got %b required 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midreset out_valid: got %b required 0", out_valid); end
    checks++; if (out_instr !== 32'h0) begin failures++; $display("FAIL midreset out_instr: got %h required 0", out_instr); end
    checks++; if (out_err !== 1'b0) begin failures++; $display("FAIL midreset out_err: got %b required 0", out_err); end
    @(posedge clk);
    #1 resetn = 1'b1;
    push_exp(1'b0, 32'h00000000);
    fork
      send_str("NOP\n");
      drain(1);
    join
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_empty_line();
    test_errors();
    test_stall();
    test_reset_midline();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard: %0d results outstanding, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/asm_encoder.md
# asm_encoder

Serial ASCII-to-MIPS instruction encoder: it accepts one text line per instruction on a byte stream and emits the 32-bit machine word. The mnemonic spellings are the same ones the debug mnemonic decoder produces. It sits behind the debug UART receiver and feeds the instruction-memory loader, so test programs can be typed in rather than pre-assembled.

## Interface
- MAX_MNEM, 6, maximum mnemonic length in characters; longer is an error.
- MAX_DIGITS, 8, maximum hex digits per operand; more is an error.
- clk  in  1  system clock.
- resetn  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_byte valid.
- in_ready  out  1  encoder accepts in_byte this cycle.
- in_byte  in  8  ASCII character.
- out_valid  out  1  result held until accepted.
- out_ready  in  1  consumer accepts result.
- out_instr  out  32  encoded instruction; 0 when out_err=1.
- out_err  out  1  qualifies out_valid; line rejected.

## Operation
- Line grammar:
  - Mnemonic: uppercase A-Z or 0-9, 1..MAX_MNEM characters.
  - Then 0-3 operands, each preceded by one or more spaces (0x20).
  - Operands are uppercase hex 0-9/A-F, 1..MAX_DIGITS digits.
  - Terminated by LF (0x0A).
  - CR (0x0D) is ignored everywhere.
  - Leading spaces and empty lines are ignored and produce no output.
- Operand values are truncated to field width:
  - reg/sa: low 5 bits.
  - imm/offset: low 16 bits.
  - target: low 26 bits.
- Operand order per class (opcode and funct values from the shared defines header):
  - AND OR XOR NOR ADD ADDU SUB SUBU SLT SLTU SLLV SRLV SRAV: rd rs rt. The variable shifts encode rt as the shifted source and rs as the amount.
  - SLL SRL SRA: rd rt sa.
  - MULT MULTU DIV DIVU: rs rt.
  - MFHI MFLO: rd.
  - MTHI MTLO JR: rs.
  - JALR: rd rs.
  - SYSC BRE ERET NOP: no operands.
    - ERET = 0x42000018.
    - NOP = 0x00000000.
    - SYSC and BRE have code field 0.
  - ANDI ORI XORI ADDI ADDIU SLTI SLTIU: rt rs imm.
  - LUI: rt imm.
  - LB LBU LH LHU LW SB SH SW: rt base offset.
  - BEQ BNE: rs rt offset.
  - BGTZ BLEZ: rs offset.
  - BGEZ BGEZAL BLTZ BLTZAL: rs offset. Opcode 000001; rt selects the variant: 00001, 10001, 00000, 10000 respectively.
  - J JAL: target.
  - MFC0: rt rd; rs=00000.
  - MTOC0: rt rd; rs=00100.
- Errors (out_err=1 result emitted at LF):
  - unknown mnemonic;
  - wrong operand count;
  - mnemonic too long;
  - too many digits;
  - any other character.
- After the first error character the rest of the line is discarded up to LF.
- FSM states:
  - IDLE: skip spaces, LF, and CR. A letter moves to MNEM and captures the first character.
  - MNEM: letter or digit appends to the mnemonic. Space moves to GAP. LF moves to EMIT.
  - GAP: spaces are skipped. A hex digit moves to OPND. LF moves to EMIT.
  - OPND: hex digits shift in 4 bits at a time. Space stores the operand and moves to GAP. LF stores the operand and moves to EMIT.
  - SKIP: consume bytes until LF, then go to EMIT.
  - EMIT: out_valid=1. On out_ready, go to IDLE and clear the mnemonic, operand count, and error flag.
- A 4th operand sends the FSM to SKIP.

## Timing
- in_ready = 1 in every state except EMIT.
- Exactly one byte is consumed per cycle while in_valid && in_ready.
- Latency: out_valid rises the cycle after LF is accepted.
- out_instr and out_err are registered and stable while out_valid && !out_ready.
- Only the final LF handshake and the out handshake may fall in the same line; no bytes are accepted during EMIT.
- The next line's first byte can be accepted the cycle after out_valid && out_ready.
- Reset values: in_ready=1, out_valid=0, out_instr=0, out_err=0, state IDLE.
- Reset mid-line discards the partial line.

## Structure
- The shared opcode/funct/REGIMM constants come from the common defines header; asm_encoder does not duplicate them.
- Operand-class codes (RRR, RRS, RR, RD, RS, JALR, NONE, IMM, LUI, MEM, BR2, BR1, REGIMM, JMP, COP0) and MAX_* parameters go in a small shared header, instenc_defs.vh.
- One sub-module, asm_lut: combinational. It maps the 48-bit packed mnemonic (left-justified, space padded) to {known, class, opcode, funct/rt-code, operand count}.
- The FSM, operand registers, and field assembly live in asm_encoder.

## Test plan
- "ADDU 3 1 2\n" -> out_instr=0x00221821, out_err=0.
- "ORI 8 9 FFFF\n" then "SW 1F 1D FFFC\n" back-to-back -> 0x3528FFFF then 0xAFBFFFFC.
- "  J 100\r\n" preceded by an empty line -> one result, 0x08000100.
- "XYZ 1\n", "ADDU 1 2\n", "ERETX\n" -> three results with out_err=1, out_instr=0. A following "ERET\n" -> 0x42000018.
- "BGEZAL 4 10\n" with out_ready held low 3 cycles:
  - result 0x04910010 is stable throughout;
  - in_ready stays 0 until the handshake;
  - a byte offered during the stall is accepted only afterwards.
- resetn pulsed low after "LW 2 " -> outputs at reset values. A following "NOP\n" -> 0x00000000, out_err=0.
